// File: rtl/array_multiplier_16bit.sv
// Unsigned 16x16 array multiplier: ripple-carry adder rows over AND-gate
// partial products, followed by a single output register stage.

module array_multiplier_16bit_ha (
  input  logic x,
  input  logic y,
  output logic s,
  output logic co
);
  assign s  = x ^ y;
  assign co = x & y;
endmodule

module array_multiplier_16bit_fa (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = x ^ y ^ ci;
  assign co = (x & y) | (x & ci) | (y & ci);
endmodule

module array_multiplier_16bit (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [31:0] product
);
  // pp[i][j] = a[j] & b[i]; row i carries weight 2^i.
  logic [15:0][15:0] pp;
  // r[i] is the 17-bit running sum after row i; r[i][0] is final product bit i.
  logic [15:0][16:0] r;
  // c[i][j] is the ripple carry out of cell j in row i.
  logic [15:1][15:0] c;
  logic [31:0]       sum;

  genvar gi, gj;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_pp_row
      for (gj = 0; gj < 16; gj++) begin : g_pp_col
        assign pp[gi][gj] = a[gj] & b[gi];
      end
    end
  endgenerate

  assign r[0] = {1'b0, pp[0]};

  // Each row adds the next shifted partial product to the upper 16 bits
  // of the previous row; the bit shifted out at the bottom is already final.
  generate
    for (gi = 1; gi < 16; gi++) begin : g_row
      array_multiplier_16bit_ha u_ha (
        .x  (pp[gi][0]),
        .y  (r[gi-1][1]),
        .s  (r[gi][0]),
        .co (c[gi][0])
      );
      for (gj = 1; gj < 16; gj++) begin : g_cell
        array_multiplier_16bit_fa u_fa (
          .x  (pp[gi][gj]),
          .y  (r[gi-1][gj+1]),
          .ci (c[gi][gj-1]),
          .s  (r[gi][gj]),
          .co (c[gi][gj])
        );
      end
      assign r[gi][16] = c[gi][15];
    end
  endgenerate

  generate
    for (gi = 0; gi < 15; gi++) begin : g_low_bits
      assign sum[gi] = r[gi][0];
    end
  endgenerate
  assign sum[31:15] = r[15];

  always_ff @(posedge clk) begin
    if (rst) begin
      product <= 32'h0000_0000;
    end else begin
      product <= sum;
    end
  end

endmodule

// File: tb/tb_array_multiplier_16bit.sv
// Self-checking bench for array_multiplier_16bit: directed and random
// operands, each expected product queued at drive time and checked one edge later.

module tb_array_multiplier_16bit;

  logic        clk;
  logic        rst;
  logic [15:0] a;
  logic [15:0] b;
  logic [31:0] product;

  logic [31:0] exp_q[$];
  int          n_checks;
  int          n_fails;

  array_multiplier_16bit dut (
    .clk     (clk),
    .rst     (rst),
    .a       (a),
    .b       (b),
    .product (product)
  );

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Drive one cycle of stimulus, queue its expected result, check after the edge.
  task automatic drive(input string tag, input logic [15:0] x, input logic [15:0] y,
                       input logic r, input logic [31:0] exp);
    logic [31:0] e;
    a   = x;
    b   = y;
    rst = r;
    exp_q.push_back(exp);
    @(posedge clk);
    @(negedge clk);
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fails++;
      $display("FAIL %s: scoreboard empty", tag);
    end else begin
      e = exp_q.pop_front();
      check(tag, product, e);
    end
  endtask

  initial begin
    logic [15:0] x, y;
    logic [31:0] e;
    n_checks = 0;
    n_fails  = 0;
    a   = 16'h0;
    b   = 16'h0;
    rst = 1'b1;
    @(negedge clk);

    drive("reset0", 16'h1234, 16'h5678, 1'b1, 32'h0);
    drive("reset1", 16'h1234, 16'h5678, 1'b1, 32'h0);
    drive("post_reset", 16'h1234, 16'h5678, 1'b0, 32'h0626_0060);

    drive("0x0",     16'd0,   16'd0,  1'b0, 32'd0);
    drive("1x1",     16'd1,   16'd1,  1'b0, 32'd1);
    drive("5x10",    16'd5,   16'd10, 1'b0, 32'd50);
    drive("15x15",   16'd15,  16'd15, 1'b0, 32'd225);
    drive("100x50",  16'd100, 16'd50, 1'b0, 32'd5000);

    drive("ffff_x1",    16'hFFFF, 16'h0001, 1'b0, 32'h0000_FFFF);
    drive("ffff_xffff", 16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE_0001);
    drive("0_xabcd",    16'h0000, 16'hABCD, 1'b0, 32'h0);
    drive("8000_x2",    16'h8000, 16'h0002, 1'b0, 32'h0001_0000);
    drive("1_x8000",    16'h0001, 16'h8000, 1'b0, 32'h0000_8000);
    drive("pow2_shift", 16'h1234, 16'h0010, 1'b0, 32'h0001_2340);

    for (int i = 0; i < 20; i++) begin
      x = 16'($urandom_range(0, 16'hFFFF));
      y = 16'($urandom_range(0, 16'hFFFF));
      e = {16'h0, x} * {16'h0, y};
      drive("random", x, y, 1'b0, e);
    end

    drive("midstream_rst", 16'hFFFF, 16'hFFFF, 1'b1, 32'h0);
    drive("after_rst_3x7", 16'd3, 16'd7, 1'b0, 32'd21);

    for (int i = 0; i < 5; i++) begin
      drive("hold", 16'h00FF, 16'h0100, 1'b0, 32'h0000_FF00);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fails);
    $finish;
  end

endmodule
